// File: rtl/col_psum_accumulator_if.sv
// rtl/col_psum_accumulator_if.sv - partial-sum input and result drain handshake bundle
interface col_psum_accumulator_if #(
  parameter int P_BITWIDTH   = 24,
  parameter int ACC_BITWIDTH = 32
);
  logic [P_BITWIDTH-1:0]   P_in;
  logic                    P_valid;
  logic                    pass_first;
  logic                    pass_last;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_BITWIDTH-1:0] out_data;
  logic                    out_last;

  // master: MAC column / writeback side; slave: the accumulator
  modport master (
    output P_in, P_valid, pass_first, pass_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  P_in, P_valid, pass_first, pass_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/col_psum_accumulator.sv
// rtl/col_psum_accumulator.sv - per-column K-tile partial-sum accumulator with result drain
module col_psum_accumulator #(
  parameter int P_BITWIDTH   = 24,
  parameter int ACC_BITWIDTH = 32,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  col_psum_accumulator_if.slave  bus,
  output logic                   drop_err,
  output logic                   acc_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t                  state;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    first_q;
  logic                    last_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [ACC_BITWIDTH-1:0] out_data_q;

  logic [ACC_BITWIDTH-1:0] mem [DEPTH];

  logic                    eff_first;
  logic                    eff_last;
  logic                    accept;
  logic [PTR_W-1:0]        wr_next;
  logic [PTR_W-1:0]        rd_next;
  logic [ACC_BITWIDTH-1:0] p_ext;
  logic [ACC_BITWIDTH:0]   sum;

  // pass flags only count on beat 0; later beats reuse the latched copy
  always_comb begin
    eff_first = first_q;
    eff_last  = last_q;
    if (wr_ptr == '0) begin
      eff_first = bus.pass_first;
      eff_last  = bus.pass_last;
    end
    accept  = bus.P_valid && (state == ACCUM);
    wr_next = wr_ptr + PTR_W'(1);
    rd_next = rd_ptr + PTR_W'(1);
    p_ext   = ACC_BITWIDTH'(bus.P_in);
    sum     = {1'b0, mem[wr_ptr]} + {1'b0, p_ext};
  end

  // Result storage is deliberately not reset; the first pass overwrites it.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[wr_ptr] <= eff_first ? p_ext : sum[ACC_BITWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      drop_err    <= 1'b0;
      acc_ovf     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.P_valid) begin
            if (wr_ptr == '0) begin
              first_q <= bus.pass_first;
              last_q  <= bus.pass_last;
            end
            if (!eff_first && sum[ACC_BITWIDTH]) begin
              acc_ovf <= 1'b1;
            end
            wr_ptr <= wr_next;
            if ((wr_ptr == LAST_PTR) && eff_last) begin
              // Entry 0 is not the one written this edge (DEPTH >= 2), so it is safe to preload.
              state       <= DRAIN;
              rd_ptr      <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b0;
              out_data_q  <= mem[0];
            end
          end
        end

        DRAIN: begin
          if (bus.P_valid) begin
            drop_err <= 1'b1;
          end
          if (bus.out_ready) begin
            if (rd_ptr == LAST_PTR) begin
              state       <= ACCUM;
              wr_ptr      <= '0;
              rd_ptr      <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
            end else begin
              rd_ptr      <= rd_next;
              out_data_q  <= mem[rd_next];
              out_last_q  <= (rd_next == LAST_PTR);
            end
          end
        end

        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_col_psum_accumulator.sv
// tb/tb_col_psum_accumulator.sv - directed table-driven bench for col_psum_accumulator
module tb_col_psum_accumulator;
  localparam int P   = 24;
  localparam int ACC = 24;
  localparam int D   = 4;

  logic clk = 1'b0;
  logic rst;
  logic drop_err;
  logic acc_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  col_psum_accumulator_if #(.P_BITWIDTH(P), .ACC_BITWIDTH(ACC)) bus ();

  col_psum_accumulator #(.P_BITWIDTH(P), .ACC_BITWIDTH(ACC), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_err (drop_err),
    .acc_ovf  (acc_ovf)
  );

  typedef struct {
    int          np;
    logic [23:0] p   [3][4];
    logic [23:0] exp [4];
    logic        ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.P_valid    = 1'b0;
    bus.P_in       = '0;
    bus.pass_first = 1'b0;
    bus.pass_last  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_drop_err"},  32'(drop_err),      32'd0);
    chk({tag, "_acc_ovf"},   32'(acc_ovf),       32'd0);
  endtask

  // Flags are inverted on beats 1..3 to show they are ignored there.
  task automatic run_pass(input logic [23:0] v [4], input logic first, input logic last,
                          input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      chk("pass_in_ready", 32'(bus.in_ready), 32'd1);
      bus.P_valid    = 1'b1;
      bus.P_in       = v[b];
      bus.pass_first = (b == 0) ? first : ~first;
      bus.pass_last  = (b == 0) ? last  : ~last;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic drain_check(input logic [23:0] e [4], input string tag);
    bus.out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_out_data"},  32'(bus.out_data),  32'(e[i]));
      chk({tag, "_out_last"},  32'(bus.out_last),  32'(i == D - 1));
      @(negedge clk);
    end
    chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [23:0] seq14 [4];
    logic [23:0] zero4 [4];
    logic [23:0] s7    [4];
    int          pat   [7];
    int          idx;

    rst = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();

    seq14 = '{24'd1, 24'd2, 24'd3, 24'd4};
    zero4 = '{24'd0, 24'd0, 24'd0, 24'd0};
    s7    = '{24'd7, 24'd8, 24'd9, 24'd10};
    pat   = '{1, 0, 0, 1, 1, 0, 1};

    vecs[0].np = 1;
    vecs[0].p[0] = '{24'd10, 24'd20, 24'd30, 24'd40};
    vecs[0].exp  = '{24'd10, 24'd20, 24'd30, 24'd40};
    vecs[0].ovf  = 1'b0;

    vecs[1].np = 3;
    vecs[1].p[0] = '{24'd1, 24'd2, 24'd3, 24'd4};
    vecs[1].p[1] = '{24'd5, 24'd5, 24'd5, 24'd5};
    vecs[1].p[2] = '{24'd100, 24'd0, 24'd0, 24'd7};
    vecs[1].exp  = '{24'd106, 24'd7, 24'd8, 24'd16};
    vecs[1].ovf  = 1'b0;

    vecs[2].np = 2;
    vecs[2].p[0] = '{24'd7, 24'd8, 24'd9, 24'd10};
    vecs[2].p[1] = '{24'd10, 24'd20, 24'd30, 24'd40};
    vecs[2].exp  = '{24'd17, 24'd28, 24'd39, 24'd50};
    vecs[2].ovf  = 1'b0;

    vecs[3].np = 2;
    vecs[3].p[0] = '{24'hFFFFFF, 24'd1, 24'd2, 24'd3};
    vecs[3].p[1] = '{24'h000002, 24'd1, 24'd1, 24'd1};
    vecs[3].exp  = '{24'h000001, 24'd2, 24'd3, 24'd4};
    vecs[3].ovf  = 1'b1;

    for (int r = 0; r < 4; r++) begin
      apply_reset();
      check_reset("vec_reset");
      for (int pp = 0; pp < vecs[r].np; pp++) begin
        run_pass(vecs[r].p[pp], pp == 0, pp == vecs[r].np - 1, D);
      end
      drain_check(vecs[r].exp, "vec_drain");
      chk("vec_acc_ovf", 32'(acc_ovf), 32'(vecs[r].ovf));
    end

    // Backpressure: entries advance only on cycles with out_ready high.
    apply_reset();
    run_pass(seq14, 1'b1, 1'b1, D);
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      bus.out_ready = pat[k][0];
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data",  32'(bus.out_data),  32'(idx + 1));
      chk("bp_out_last",  32'(bus.out_last),  32'(idx == D - 1));
      @(negedge clk);
      if (pat[k] != 0) idx++;
    end
    bus.out_ready = 1'b0;
    chk("bp_done_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.in_ready),  32'd1);

    // Beat during drain is dropped and leaves the buffer intact.
    apply_reset();
    run_pass(seq14, 1'b1, 1'b1, D);
    bus.out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      bus.P_valid = (i == 0);
      bus.P_in    = (i == 0) ? 24'd99 : 24'd0;
      chk("drop_out_data", 32'(bus.out_data), 32'(i + 1));
      @(negedge clk);
    end
    idle_inputs();
    bus.out_ready = 1'b0;
    chk("drop_err_set",  32'(drop_err),     32'd1);
    chk("drop_in_ready", 32'(bus.in_ready), 32'd1);
    run_pass(zero4, 1'b0, 1'b1, D);
    drain_check(seq14, "drop_reacc");
    chk("drop_err_sticky", 32'(drop_err), 32'd1);
    apply_reset();
    chk("drop_err_clear", 32'(drop_err), 32'd0);

    // Reset after two beats of a pass.
    run_pass(seq14, 1'b1, 1'b1, 2);
    apply_reset();
    check_reset("rst_mid_pass");

    // Reset after one drained entry.
    run_pass(seq14, 1'b1, 1'b1, D);
    bus.out_ready = 1'b1;
    chk("rst_drain_first", 32'(bus.out_data), 32'd1);
    @(negedge clk);
    chk("rst_drain_second", 32'(bus.out_data), 32'd2);
    apply_reset();
    check_reset("rst_mid_drain");
    @(negedge clk);
    chk("rst_hold_valid", 32'(bus.out_valid), 32'd0);

    run_pass(s7, 1'b1, 1'b1, D);
    drain_check(s7, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/col_psum_accumulator.md
# col_psum_accumulator

Per-column partial-sum accumulator at the bottom edge of the systolic MAC array. Takes the 24-bit partial sums leaving the last MAC row of one column and adds them across K-tiles into a DEPTH-entry result buffer. Once the final K-tile pass is complete, it drains the finished results to the writeback path over a valid/ready handshake. The array instantiates one block per column.

## Interface
- `P_BITWIDTH`, 24, width of incoming partial sum (matches MAC `P_out`)
- `ACC_BITWIDTH`, 32, accumulator/result width; must be ≥ `P_BITWIDTH`
- `DEPTH`, 16, result entries per tile (output rows); power of two, ≥ 2
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `P_in`  in  P_BITWIDTH  partial sum from bottom MAC of this column
- `P_valid`  in  1  `P_in` valid this cycle (driven from bottom MAC `A_ready`)
- `pass_first`  in  1  sampled with beat 0 of a pass: overwrite instead of accumulate
- `pass_last`  in  1  sampled with beat 0 of a pass: drain after this pass
- `in_ready`  out  1  block accepts `P_valid` beats
- `out_valid`  out  1  `out_data` holds a finished result
- `out_ready`  in  1  downstream accepts `out_data`
- `out_data`  out  ACC_BITWIDTH  finished result, entry order 0..DEPTH-1
- `out_last`  out  1  high with the entry DEPTH-1 beat
- `drop_err`  out  1  sticky: a `P_valid` beat arrived while `in_ready`=0
- `acc_ovf`  out  1  sticky: an accumulate carried out of ACC_BITWIDTH

## Operation
- Two states: ACCUM (in_ready=1) and DRAIN (in_ready=0).
- ACCUM: each `P_valid` beat targets `buf[wr_ptr]`; wr_ptr increments modulo DEPTH.
- Beat with wr_ptr=0 latches `pass_first`/`pass_last` into `first_q`/`last_q` and applies `pass_first` directly; later beats of the pass use `first_q`. Both inputs are ignored on all other beats.
- Overwrite: `buf[wr_ptr] <= zext(P_in)`. Accumulate: `buf[wr_ptr] <= buf[wr_ptr] + zext(P_in)`.
- Accumulation is unsigned and wraps mod 2^ACC_BITWIDTH. A carry out sets `acc_ovf`.
- Beat with wr_ptr=DEPTH-1 and effective last=1: next state DRAIN, rd_ptr=0. If last=0: stay in ACCUM, and wr_ptr wraps to 0 (new pass).
- DRAIN: `out_valid`=1, `out_data`=`buf[rd_ptr]`, `out_last`=(rd_ptr==DEPTH-1).
- A handshake (`out_valid & out_ready`) increments rd_ptr. Handshake at DEPTH-1: next state ACCUM, wr_ptr=0, rd_ptr=0.
- `P_valid` while in DRAIN: beat is discarded, buffer unchanged, `drop_err` set.
- Outputs not in DRAIN: `out_valid`=0, `out_last`=0, `out_data`=0.
- Buffer contents are not reset. Software must issue `pass_first`=1 on the first pass after reset.

## Timing
- Reset (rst=1 at posedge): state ACCUM, wr_ptr=rd_ptr=0, first_q=last_q=0, in_ready=1, out_valid=0, out_last=0, out_data=0, drop_err=0, acc_ovf=0. Reset overrides all other activity, including mid-pass and mid-drain: partial tile is abandoned and no further outputs are produced.
- Accumulate latency: buffer entry is updated at the posedge sampling the beat. Back-to-back beats every cycle are supported, including same-entry accumulate across passes (DEPTH ≥ 2 guarantees no read-after-write hazard within a cycle).
- Final beat at edge N → `out_valid`=1 from cycle N+1, carrying the value that includes that final beat.
- Drain throughput: one entry per cycle with `out_ready` held high. DEPTH entries occupy cycles N+1..N+DEPTH; `in_ready`=1 again from cycle N+DEPTH+1.
- Backpressure: with `out_ready`=0, `out_data`/`out_last` hold stable and `out_valid` stays 1.
- `pass_first` and `pass_last` may be set together (single-pass tile).

## Test plan
- Single-pass tile (DEPTH=4): pass_first=pass_last=1; P_in 10,20,30,40 on consecutive cycles; out_ready=1 → outputs 10,20,30,40 on four consecutive cycles with out_last on 40; in_ready returns 1 the following cycle.
- Three-pass accumulate: passes P_in=1,2,3,4 (first), then 5,5,5,5, then 100,0,0,7 (last) → outputs 106,7,8,16.
- Backpressure: single pass 1..4; toggle out_ready 1,0,0,1,1,0,1 → each entry appears exactly once, in order; out_data stable while stalled.
- Drop during drain: issue P_valid (P_in=99) during DRAIN → drop_err=1 and stays 1, drained values unchanged; rst clears drop_err to 0.
- Overflow wrap: ACC_BITWIDTH=24; entry 0 first pass 0xFFFFFF, second pass 0x000002 (last) → out_data 0x000001 for entry 0, acc_ovf=1.
- Reset mid-operation: rst asserted after 2 of 4 beats, and separately after 1 drained entry → all outputs return to reset values next cycle. A subsequent single-pass tile 7,8,9,10 drains exactly 7,8,9,10.
